dadda_mac_acc: RTL and testbench
================================

Name: dadda_mac_acc

Overview:
- Downstream consumer of the 8x8 Dadda multiplier array.
- Takes the array's two partial outputs: high half (bits 15:8) and low half (11-bit, bits 10:0 with overlap carries).
- Merges them into a registered 16-bit product, then accumulates products over a frame delimited by a last flag.
- Presents the frame sum via a valid/ready handshake. Forms the MAC back end of the multiplier datapath.

Parameters:
ACC_W, 24, accumulator and result width (must be >= 16)
CNT_W, 8, width of the per-frame beat counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_hi  input  8  high partial product, weight 2^8
in_lo  input  11  low partial product, weight 2^0
in_last  input  1  beat is last of frame
clr  input  1  synchronous frame abort
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  frame sum
out_cnt  output  CNT_W  beats in frame
out_ovf  output  1  accumulator overflowed during frame

Behaviour:
- Reset is asynchronous and active-low, on rst_n; single clock clk. All state clears immediately on rst_n=0: state=IDLE, in_ready=0 while reset is held, out_valid=0, out_acc=0, out_cnt=0, out_ovf=0, pipeline valid=0. in_ready=1 the first cycle after release.
- Beat accepted when in_valid && in_ready.
- Stage 1 (merge), on accept: p_q <= ({in_hi,8'b0} + {5'b0,in_lo}) mod 2^16. v_q <= 1 and l_q <= in_last on accept; otherwise v_q <= 0.
- Stage 2 (accumulate), when v_q:
  - acc <= acc + zero-extended p_q.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Overflow: carry out of ACC_W bits sets sticky ovf.
- States:
  - IDLE: no beat yet in frame; in_ready=1; go to ACCUM on first accept.
  - ACCUM: in_ready=1 until a last beat is accepted, then 0. When stage 2 consumes the last beat, go to DONE.
  - DONE: out_valid=1. out_acc/out_cnt/out_ovf are held stable while out_valid && !out_ready. in_ready=0. On out_ready: acc=0, cnt=0, ovf=0, go to IDLE.
- A single-beat frame (first beat has in_last=1) goes IDLE -> DONE via the pipeline.
- Latency: last beat accepted at cycle N gives out_valid=1 at cycle N+2, with the last product included.
- in_ready drops combinationally the cycle after last is accepted (cycle N+1). No beat of the next frame may enter before the result handshake.
- clr:
  - In IDLE/ACCUM: flushes v_q, sets acc=0, cnt=0, ovf=0, state=IDLE. Any beat accepted in the same cycle is dropped. clr has priority over accumulate.
  - In DONE: ignored; the result is not lost.
- in_valid with in_ready=0: the beat is not consumed. The upstream must hold it; the block does not sample it.
- Merge arithmetic is modulo 2^16. A correctly paired hi/lo from the array always yields the true a*b <= 65025.

Optional Feature:
- Macro MAC_ACC_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1 on overflow. out_ovf is sticky high for the frame, and later beats leave acc at max.
- Undefined: the accumulator wraps modulo 2^ACC_W. out_ovf still reports a wrap (sticky), but acc is the wrapped value.

Test Plan:
- Reset mid-frame: after 2 beats, assert rst_n=0 -> out_valid=0, out_acc=0, out_cnt=0 immediately; after release, in_ready=1 and state is IDLE.
- Single beat hi=0xFC, lo=0x201, last=1 at cycle N -> out_valid at N+2, out_acc=0xFE01, out_cnt=1, out_ovf=0.
- Three-beat frame: (hi=0,lo=15), (hi=0x01,lo=0x004), (hi=0,lo=0x7FF) back-to-back -> out_acc=15+260+2047=2322, out_cnt=3. in_ready=0 from the cycle after last until the handshake.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_acc stable, in_ready=0, clr pulse ignored. out_ready=1 -> IDLE next cycle, acc cleared.
- Abort: 2 beats accepted, then clr with a concurrent beat -> next frame of one beat (lo=7,last) gives out_acc=7, out_cnt=1.
- Overflow with ACC_W=16: beats 0xFE01 then 0x0200 -> with MAC_ACC_SAT_EN out_acc=0xFFFF, out_ovf=1; without it out_acc=0x0001, out_ovf=1.

Source files
------------

// File: rtl/dadda_mac_acc.sv
// ---------------------------------------------------------------------------
// dadda_mac_acc
//   MAC back end for the 8x8 Dadda multiplier array. It merges the array's
//   high half (weight 2^8) and 11-bit low half (weight 2^0, carries the
//   overlap) into a registered 16-bit product. It then accumulates the
//   products of one frame, which ends at a beat with in_last. The frame sum
//   is presented on a valid/ready handshake.
//
//   Pipeline: stage 1 merges (p_q/v_q/l_q), stage 2 accumulates.
//   A last beat accepted in cycle N gives out_valid in cycle N+2.
//
//   Build option:
//     MAC_ACC_SAT_EN  defined   -> accumulator saturates at 2^ACC_W-1
//                     undefined -> accumulator wraps modulo 2^ACC_W
//   In both builds out_ovf is a sticky flag for the frame.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input beat handshake
//   in_hi[7:0]            high partial product
//   in_lo[10:0]           low partial product
//   in_last               beat closes the frame
//   clr                   synchronous frame abort (ignored while in DONE)
//   out_valid/out_ready   result handshake
//   out_acc[ACC_W-1:0]    frame sum
//   out_cnt[CNT_W-1:0]    beats in frame (saturating)
//   out_ovf               accumulator overflowed during the frame
// ---------------------------------------------------------------------------
module dadda_mac_acc #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_hi,
   input  logic [10:0]      in_lo,
   input  logic             in_last,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state;
   logic [15:0]      p_q;
   logic             v_q;
   logic             l_q;
   logic             last_pend;   // last beat taken, waiting for the result handshake
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             accept;
   logic [15:0]      merged;
   logic [ACC_W:0]   sum;

   // Merge wraps at 16 bits. A correctly paired hi/lo never exceeds 65025.
   assign merged = {in_hi, 8'b0} + {5'b0, in_lo};

   // The extra MSB of sum is the carry out of the accumulator.
   assign sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, p_q};

   // rst_n is gated in so that in_ready stays low while reset is held. The
   // state register alone would read IDLE during reset and raise in_ready.
   assign in_ready = rst_n & (state != DONE) & ~last_pend;
   assign accept   = in_valid & in_ready;

   assign out_valid = (state == DONE);
   assign out_acc   = acc;
   assign out_cnt   = cnt;
   assign out_ovf   = ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         p_q       <= '0;
         v_q       <= 1'b0;
         l_q       <= 1'b0;
         last_pend <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
      end else if (state == DONE) begin
         // Result is held until it is taken. clr has no effect here.
         v_q <= 1'b0;
         if (out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            last_pend <= 1'b0;
            state     <= IDLE;
         end
      end else if (clr) begin
         // Abort: flush stage 1, drop any beat offered this cycle, clear the sum.
         v_q       <= 1'b0;
         l_q       <= 1'b0;
         last_pend <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         state     <= IDLE;
      end else begin
         // Stage 1: merge
         v_q <= accept;
         if (accept) begin
            p_q <= merged;
            l_q <= in_last;
            if (in_last)
               last_pend <= 1'b1;
            if (state == IDLE)
               state <= ACCUM;
         end
         // Stage 2: accumulate
         if (v_q) begin
`ifdef MAC_ACC_SAT_EN
            acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
            if (sum[ACC_W])
               ovf <= 1'b1;
            if (cnt != {CNT_W{1'b1}})
               cnt <= cnt + 1'b1;
            // The last beat of a frame blocks new accepts, so this cannot
            // collide with the IDLE->ACCUM move above.
            if (l_q)
               state <= DONE;
         end
      end
   end

endmodule

// File: tb/tb_dadda_mac_acc.sv
module tb_dadda_mac_acc;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_last, clr, out_ready;
   logic [7:0]  in_hi;
   logic [10:0] in_lo;
   logic        in_ready, out_valid, out_ovf;
   logic [23:0] out_acc;
   logic [7:0]  out_cnt;

   // Second instance with a 16-bit accumulator for the overflow scenario
   logic        o_in_valid, o_in_last, o_clr, o_out_ready;
   logic [7:0]  o_in_hi;
   logic [10:0] o_in_lo;
   logic        o_in_ready, o_out_valid, o_out_ovf;
   logic [15:0] o_out_acc;
   logic [7:0]  o_out_cnt;

   int checks = 0;
   int errors = 0;

   dadda_mac_acc #(.ACC_W(24), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_hi(in_hi), .in_lo(in_lo), .in_last(in_last), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_cnt(out_cnt), .out_ovf(out_ovf)
   );

   dadda_mac_acc #(.ACC_W(16), .CNT_W(8)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
      .in_hi(o_in_hi), .in_lo(o_in_lo), .in_last(o_in_last), .clr(o_clr),
      .out_valid(o_out_valid), .out_ready(o_out_ready), .out_acc(o_out_acc),
      .out_cnt(o_out_cnt), .out_ovf(o_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat for exactly one edge (caller ensures in_ready=1).
   task automatic beat(input logic [7:0] hi, input logic [10:0] lo, input logic last);
      in_valid = 1'b1; in_hi = hi; in_lo = lo; in_last = last;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 0; in_hi = 0; in_lo = 0; in_last = 0; clr = 0; out_ready = 0;
      o_in_valid = 0; o_in_hi = 0; o_in_lo = 0; o_in_last = 0; o_clr = 0; o_out_ready = 0;
      #12;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_acc !== 24'd0 || out_cnt !== 8'd0 || out_ovf !== 1'b0) begin
         errors++; $display("FAIL reset_outs got acc=%h cnt=%0d ovf=%b exp 0", out_acc, out_cnt, out_ovf); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_reset_mid_frame();
      beat(8'h00, 11'd10, 1'b0);
      beat(8'h00, 11'd20, 1'b0);
      tick();                               // let the second beat accumulate
      checks++; if (out_acc !== 24'd30 || out_cnt !== 8'd2) begin
         errors++; $display("FAIL mid_frame_pre got acc=%0d cnt=%0d exp 30/2", out_acc, out_cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_acc !== 24'd0 || out_cnt !== 8'd0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_frame_async got v=%b acc=%0d cnt=%0d rdy=%b exp 0/0/0/0",
                            out_valid, out_acc, out_cnt, in_ready); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_frame_release got rdy=%b v=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_single_beat();
      beat(8'hFC, 11'h201, 1'b1);           // edge N
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL single_n1 got v=%b rdy=%b exp 0/0", out_valid, in_ready); end
      tick();                               // N+2
      checks++; if (out_valid !== 1'b1 || out_acc !== 24'hFE01 || out_cnt !== 8'd1 || out_ovf !== 1'b0) begin
         errors++; $display("FAIL single_result got v=%b acc=%h cnt=%0d ovf=%b exp 1/00fe01/1/0",
                            out_valid, out_acc, out_cnt, out_ovf); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_acc !== 24'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL single_handshake got v=%b acc=%h rdy=%b exp 0/0/1", out_valid, out_acc, in_ready); end
   endtask

   // 0xFF00 + 0x7FF = 0x106FF, merge keeps 0x06FF
   task automatic test_merge_wrap();
      beat(8'hFF, 11'h7FF, 1'b1);
      tick();
      checks++; if (out_valid !== 1'b1 || out_acc !== 24'h0006FF || out_ovf !== 1'b0) begin
         errors++; $display("FAIL merge_wrap got v=%b acc=%h ovf=%b exp 1/0006ff/0", out_valid, out_acc, out_ovf); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      beat(8'h00, 11'd15, 1'b0);
      beat(8'h01, 11'h004, 1'b0);
      beat(8'h00, 11'h7FF, 1'b1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b exp 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_acc !== 24'd2322 || out_cnt !== 8'd3) begin
         errors++; $display("FAIL b2b_result got v=%b acc=%0d cnt=%0d exp 1/2322/3", out_valid, out_acc, out_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_done got %b exp 0", in_ready); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_acc !== 24'd0 || out_cnt !== 8'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_handshake got v=%b acc=%0d cnt=%0d rdy=%b exp 0/0/0/1",
                            out_valid, out_acc, out_cnt, in_ready); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      beat(8'h00, 11'd100, 1'b1);
      tick();
      in_valid = 1'b1; in_hi = 8'h00; in_lo = 11'd55; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         clr = (i == 2);
         tick();
         if (out_valid !== 1'b1 || out_acc !== 24'd100 || out_cnt !== 8'd1 || in_ready !== 1'b0) bad++;
      end
      clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      checks++; if (bad != 0) begin
         errors++; $display("FAIL backpressure_hold got %0d bad cycles (v=%b acc=%0d rdy=%b) exp 0",
                            bad, out_valid, out_acc, in_ready); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_acc !== 24'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL backpressure_release got v=%b acc=%0d rdy=%b exp 0/0/1", out_valid, out_acc, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_acc !== 24'd0) begin
         errors++; $display("FAIL backpressure_no_leak got v=%b acc=%0d exp 0/0", out_valid, out_acc); end
   endtask

   task automatic test_abort();
      beat(8'h00, 11'd5, 1'b0);
      beat(8'h00, 11'd6, 1'b0);
      in_valid = 1'b1; in_lo = 11'd9; clr = 1'b1;
      tick();
      in_valid = 1'b0; clr = 1'b0;
      checks++; if (out_acc !== 24'd0 || out_cnt !== 8'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL abort_clear got acc=%0d cnt=%0d rdy=%b exp 0/0/1", out_acc, out_cnt, in_ready); end
      tick();
      checks++; if (out_acc !== 24'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL abort_flush got acc=%0d v=%b exp 0/0", out_acc, out_valid); end
      beat(8'h00, 11'd7, 1'b1);
      tick();
      checks++; if (out_valid !== 1'b1 || out_acc !== 24'd7 || out_cnt !== 8'd1) begin
         errors++; $display("FAIL abort_next_frame got v=%b acc=%0d cnt=%0d exp 1/7/1", out_valid, out_acc, out_cnt); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   // 0xFE01 + 0x0200 = 0x10001 in a 16-bit accumulator
   task automatic test_overflow();
      logic [15:0] exp_acc;
`ifdef MAC_ACC_SAT_EN
      exp_acc = 16'hFFFF;
`else
      exp_acc = 16'h0001;
`endif
      o_in_valid = 1'b1; o_in_hi = 8'hFC; o_in_lo = 11'h201; o_in_last = 1'b0;
      tick();
      o_in_hi = 8'h02; o_in_lo = 11'h000; o_in_last = 1'b1;
      tick();
      o_in_valid = 1'b0; o_in_last = 1'b0;
      tick();
      checks++; if (o_out_valid !== 1'b1 || o_out_acc !== exp_acc || o_out_ovf !== 1'b1 || o_out_cnt !== 8'd2) begin
         errors++; $display("FAIL overflow got v=%b acc=%h ovf=%b cnt=%0d exp 1/%h/1/2",
                            o_out_valid, o_out_acc, o_out_ovf, o_out_cnt, exp_acc); end
      o_out_ready = 1'b1; tick(); o_out_ready = 1'b0;
      checks++; if (o_out_ovf !== 1'b0 || o_out_acc !== 16'd0) begin
         errors++; $display("FAIL overflow_clear got ovf=%b acc=%h exp 0/0", o_out_ovf, o_out_acc); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_frame();
      test_single_beat();
      test_merge_wrap();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
